// File: rtl/inference_sequencer.sv
// Single-frame controller: collects nine kernel weights, gates one frame of pixels into the
// conv/pool/NN pipeline and captures the network result. Define SEQ_FLUSH_TIMEOUT_EN for a FLUSH watchdog.
module inference_sequencer #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int IMG_W            = 28,
    parameter int IMG_H            = 28,
    parameter int FLUSH_TIMEOUT    = 4096,
    localparam int DATA_W = INTEGER_BITS + FIXED_POINT_BITS,
    localparam int PIXELS = IMG_W * IMG_H,
    localparam int CNT_W  = $clog2(PIXELS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    input  logic [DATA_W-1:0]     i_kernel_word,
    input  logic                  i_kernel_valid,
    output logic                  o_kernel_ready,
    output logic                  o_kernel_reset,
    output logic [9*DATA_W-1:0]   o_kernel_vals,
    input  logic [DATA_W-1:0]     i_pix_data,
    input  logic                  i_pix_valid,
    output logic                  o_pix_ready,
    output logic [DATA_W-1:0]     o_pix_data,
    output logic                  o_pix_valid,
    input  logic                  i_nn_valid,
    input  logic [2*DATA_W-1:0]   i_nn_data,
    output logic [2*DATA_W-1:0]   o_result,
    output logic                  o_result_valid,
    output logic                  o_done,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_APPLY,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [3:0]          kidx_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [DATA_W-1:0]   kernel_reg [9];
    logic [DATA_W-1:0]   pix_data_reg;
    logic                pix_valid_reg;
    logic [2*DATA_W-1:0] result_reg;
    logic                result_valid_reg;

    logic start_accept;
    logic kernel_accept;
    logic pix_ready;
    logic pix_accept;
    logic last_pixel;
    logic capture;
    logic timeout_hit;

    assign start_accept  = (state_reg == ST_IDLE) && i_start;
    assign kernel_accept = (state_reg == ST_LOAD) && i_kernel_valid;
    assign pix_ready     = (state_reg == ST_STREAM) && (count_reg < CNT_W'(PIXELS));
    assign pix_accept    = pix_ready && i_pix_valid;
    assign last_pixel    = pix_accept && (count_reg == CNT_W'(PIXELS - 1));
    // Only the first network result of a frame is kept.
    assign capture       = i_nn_valid && !result_valid_reg &&
                           ((state_reg == ST_STREAM) || (state_reg == ST_FLUSH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        o_busy         = (state_reg != ST_IDLE);
        o_kernel_ready = 1'b0;
        o_kernel_reset = 1'b0;
        o_done         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_accept) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_kernel_ready = 1'b1;
                if (kernel_accept && (kidx_reg == 4'd8)) state_next = ST_APPLY;
            end
            ST_APPLY: begin
                o_kernel_reset = 1'b1;
                state_next     = ST_STREAM;
            end
            ST_STREAM: begin
                if (last_pixel) state_next = result_valid_reg ? ST_DONE : ST_FLUSH;
            end
            ST_FLUSH: begin
                if (capture || result_valid_reg || timeout_hit) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            kidx_reg         <= '0;
            count_reg        <= '0;
            pix_data_reg     <= '0;
            pix_valid_reg    <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            pix_valid_reg <= pix_accept;
            if (pix_accept) pix_data_reg <= i_pix_data;
            if (start_accept) begin
                kidx_reg         <= '0;
                count_reg        <= '0;
                result_reg       <= '0;
                result_valid_reg <= 1'b0;
            end else begin
                if (kernel_accept) kidx_reg <= kidx_reg + 4'd1;
                if (pix_accept) count_reg <= count_reg + CNT_W'(1);
                if (capture) begin
                    result_reg       <= i_nn_data;
                    result_valid_reg <= 1'b1;
                end
            end
        end
    end

    // Weights persist across frames until the next LOAD overwrites them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) kernel_reg[k] <= '0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (kernel_accept && (kidx_reg == 4'(k))) kernel_reg[k] <= i_kernel_word;
            end
        end
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_kernel_pack
        assign o_kernel_vals[gi*DATA_W +: DATA_W] = kernel_reg[gi];
    end

`ifdef SEQ_FLUSH_TIMEOUT_EN
    localparam int TO_W = $clog2(FLUSH_TIMEOUT + 1);

    logic [TO_W-1:0] flush_cnt_reg;
    logic            timeout_reg;

    assign timeout_hit = (state_reg == ST_FLUSH) && (flush_cnt_reg == TO_W'(FLUSH_TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || (state_reg != ST_FLUSH)) begin
            flush_cnt_reg <= '0;
        end else begin
            flush_cnt_reg <= flush_cnt_reg + TO_W'(1);
        end
    end

    // A capture landing on the expiry cycle takes priority over the timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_accept) begin
            timeout_reg <= 1'b0;
        end else if (timeout_hit && !capture && !result_valid_reg) begin
            timeout_reg <= 1'b1;
        end
    end

    assign o_timeout = timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    assign o_pix_ready    = pix_ready;
    assign o_pix_data     = pix_data_reg;
    assign o_pix_valid    = pix_valid_reg;
    assign o_result       = result_reg;
    assign o_result_valid = result_valid_reg;

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench for inference_sequencer on a 4x4 frame; expectations come from frame-level rules.
module tb_inference_sequencer;
    localparam int IB  = 9;
    localparam int FB  = 4;
    localparam int DW  = IB + FB;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int PIX = W * H;
    localparam int FT  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic              busy;
    logic [DW-1:0]     kernel_word;
    logic              kernel_valid;
    logic              kernel_ready;
    logic              kernel_reset;
    logic [9*DW-1:0]   kernel_vals;
    logic [DW-1:0]     pix_in;
    logic              pix_in_valid;
    logic              pix_ready;
    logic [DW-1:0]     pix_out;
    logic              pix_out_valid;
    logic              nn_valid;
    logic [2*DW-1:0]   nn_data;
    logic [2*DW-1:0]   result;
    logic              result_valid;
    logic              done;
    logic              timeout;

    inference_sequencer #(
        .INTEGER_BITS    (IB),
        .FIXED_POINT_BITS(FB),
        .IMG_W           (W),
        .IMG_H           (H),
        .FLUSH_TIMEOUT   (FT)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .o_busy         (busy),
        .i_kernel_word  (kernel_word),
        .i_kernel_valid (kernel_valid),
        .o_kernel_ready (kernel_ready),
        .o_kernel_reset (kernel_reset),
        .o_kernel_vals  (kernel_vals),
        .i_pix_data     (pix_in),
        .i_pix_valid    (pix_in_valid),
        .o_pix_ready    (pix_ready),
        .o_pix_data     (pix_out),
        .o_pix_valid    (pix_out_valid),
        .i_nn_valid     (nn_valid),
        .i_nn_data      (nn_data),
        .o_result       (result),
        .o_result_valid (result_valid),
        .o_done         (done),
        .o_timeout      (timeout)
    );

    typedef struct {
        logic [2*DW-1:0] res;
        logic            valid;
        logic            tmo;
    } exp_t;

    logic [DW-1:0]   pix_q  [$];
    logic [9*DW-1:0] kern_q [$];
    exp_t            res_q  [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever the DUT presents one.
    logic [DW-1:0]   mon_pix;
    logic [9*DW-1:0] mon_kern;
    exp_t            mon_res;

    always @(negedge clk) begin
        if (pix_out_valid) begin
            if (pix_q.size() == 0) begin
                check("pix_unexpected", {255'd0, pix_out_valid}, 256'd0);
            end else begin
                mon_pix = pix_q.pop_front();
                check("pix_data", pix_out, mon_pix);
                $display("pixel forwarded %0h", pix_out);
            end
        end
        if (kernel_reset) begin
            if (kern_q.size() == 0) begin
                check("kernel_unexpected", {255'd0, kernel_reset}, 256'd0);
            end else begin
                mon_kern = kern_q.pop_front();
                check("kernel_vals", kernel_vals, mon_kern);
                $display("kernel applied %0h", kernel_vals);
            end
        end
        if (done) begin
            if (res_q.size() == 0) begin
                check("done_unexpected", {255'd0, done}, 256'd0);
            end else begin
                mon_res = res_q.pop_front();
                check("result", result, mon_res.res);
                check("result_valid", result_valid, mon_res.valid);
                check("timeout", timeout, mon_res.tmo);
                $display("frame done result %0h valid %0b timeout %0b", result, result_valid, timeout);
            end
        end
    end

    // nn_pix >= 0: result pulsed once nn_pix pixels are in; nn_delay > 0: result pulsed that many
    // cycles after the last accept; rst_pix >= 0: reset after that many pixels.
    task automatic run_frame(input bit fixed, input bit kgap, input int n_offer, input bit pix_gaps,
                             input int nn_pix, input int nn_delay, input int rst_pix);
        logic [DW-1:0]   w [9];
        logic [9*DW-1:0] kv;
        logic [2*DW-1:0] nn_val;
        logic [DW-1:0]   pval;
        exp_t            e;
        int              acc, offered, since, k, lcyc, d_exp;
        bit              nn1, nn2, fire, finished;

        nn_val = fixed ? {13'h0ABC, 13'h0123} : (2*DW)'($urandom);
        for (int i = 0; i < 9; i++) begin
            w[i] = fixed ? DW'(i + 1) : DW'($urandom);
            kv[i*DW +: DW] = w[i];
        end
        if (nn_pix >= 0) d_exp = 1;
        else if (nn_delay > 0) d_exp = nn_delay + 1;
        else begin
`ifdef SEQ_FLUSH_TIMEOUT_EN
            d_exp = FT + 1;
`else
            d_exp = 0;
`endif
        end
        e.valid = (nn_pix >= 0) || (nn_delay > 0);
        e.res   = e.valid ? nn_val : '0;
        e.tmo   = !e.valid;
        kern_q.push_back(kv);
        if (rst_pix < 0 && d_exp > 0) res_q.push_back(e);

        @(negedge clk);
        check("idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_busy", busy, 1);

        k = 0;
        lcyc = 0;
        while (k < 9) begin
            check("kernel_ready", kernel_ready, 1);
            fire = kgap ? (lcyc % 2 == 1) : (fixed ? 1'b1 : ($urandom_range(0, 3) != 0));
            kernel_valid = fire;
            kernel_word  = fire ? w[k] : DW'($urandom);
            nn_valid     = fixed ? 1'b0 : ($urandom_range(0, 1) == 1);
            nn_data      = (2*DW)'($urandom);
            @(negedge clk);
            lcyc++;
            if (fire) k++;
        end

        kernel_valid = 1'b0;
        check("apply_strobe", kernel_reset, 1);
        check("apply_kernel_ready", kernel_ready, 0);
        check("apply_pix_ready", pix_ready, 0);
        nn_valid = fixed ? 1'b0 : ($urandom_range(0, 1) == 1);
        nn_data  = (2*DW)'($urandom);
        @(negedge clk);
        check("stream_strobe", kernel_reset, 0);

        acc = 0; offered = 0; since = 0; nn1 = 0; nn2 = 0; finished = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (acc == PIX) since++;
            check("pix_ready", pix_ready, (acc < PIX) ? 1 : 0);
            if (since >= 1 && d_exp > 0) check("done_pulse", done, (since == d_exp) ? 1 : 0);
            if (since >= 1 && d_exp == 0) check("busy_flush", busy, 1);
            if ((d_exp > 0 && since == d_exp) || (d_exp == 0 && since == 120)) begin
                finished = 1;
                break;
            end
            if (rst_pix >= 0 && acc == rst_pix) begin
                rst = 1'b1; start = 1'b0; pix_in_valid = 1'b0; nn_valid = 1'b0;
                @(negedge clk);
                check("reset_outputs", {busy, kernel_ready, kernel_reset, kernel_vals, pix_ready, pix_out,
                                        pix_out_valid, result, result_valid, done, timeout}, '0);
                check("reset_pix_drained", pix_q.size(), 0);
                rst = 1'b0;
                return;
            end
            start    = (since == 0 && !fixed) ? ($urandom_range(0, 7) == 0) : 1'b0;
            nn_valid = 1'b0;
            nn_data  = (2*DW)'($urandom);
            if (nn_pix >= 0 && !nn1 && acc == nn_pix) begin
                nn_valid = 1'b1; nn_data = nn_val; nn1 = 1;
            end else if (nn_pix >= 0 && nn1 && !nn2 && acc >= nn_pix + 3 && acc < PIX) begin
                nn_valid = 1'b1; nn_data = ~nn_val; nn2 = 1;
            end else if (nn_delay > 0 && since == nn_delay) begin
                nn_valid = 1'b1; nn_data = nn_val;
            end
            fire = (offered < n_offer) && (pix_gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
            pval = fixed ? DW'(13'h010 + offered) : DW'($urandom);
            pix_in_valid = fire;
            pix_in       = pval;
            if (fire) begin
                if (acc < PIX) begin
                    pix_q.push_back(pval);
                    acc++;
                end
                offered++;
            end
            @(negedge clk);
        end
        if (!finished) check("frame_bound", since, d_exp);

        start = 1'b0;
        pix_in_valid = 1'b0;
        if (d_exp > 0) begin
            nn_valid = 1'b1;
            nn_data  = ~nn_val;
            @(negedge clk);
            nn_valid = 1'b0;
            check("result_hold", result, e.res);
            check("result_valid_hold", result_valid, e.valid);
            check("timeout_hold", timeout, e.tmo);
            check("idle_after_done", busy, 0);
        end else begin
            rst = 1'b1;
            nn_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check("recover_busy", busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kernel_word = '0; kernel_valid = 1'b0;
        pix_in = '0; pix_in_valid = 1'b0; nn_valid = 1'b0; nn_data = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, kernel_ready, kernel_reset, kernel_vals, pix_ready, pix_out,
                              pix_out_valid, result, result_valid, done, timeout}, '0);
        rst = 1'b0;

        run_frame(1, 0, 16, 0, -1, 3, -1);
        run_frame(0, 1, 16, 0, -1, 2, -1);
        run_frame(0, 0, 20, 0, -1, 6, -1);
        run_frame(0, 0, 16, 0, 10, 0, -1);
        run_frame(0, 0, 16, 0, -1, 3, 7);
        run_frame(0, 0, 16, 0, -1, 1, -1);
        run_frame(0, 0, 16, 1, -1, 0, -1);
        for (int i = 0; i < 4; i++) begin
            run_frame(0, ($urandom_range(0, 1) == 1), 16, 1,
                      (i % 2 == 0) ? int'($urandom_range(0, 12)) : -1,
                      (i % 2 == 0) ? 0 : int'($urandom_range(1, 5)), -1);
        end

        repeat (3) @(negedge clk);
        check("queues_empty", pix_q.size() + kern_q.size() + res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
